// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal between the memory port arbiter, its two requesters
// (CPU and debug) and the single-port memory.
//   cpu_*      : CPU request set (req/we/addr/wdata in; gnt/rvalid/rdata out)
//   dbg_*      : debug request set, same meaning as the CPU set
//   dbg_lock   : debug asks for exclusive memory ownership
//   dbg_locked : exclusive ownership currently held by debug
//   cpu_halted : CPU held in reset; its requests are masked
//   mem_*      : single-port memory command; mem_rdata valid one cycle after a read
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters and memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dbg_lock;
    logic              dbg_locked;
    logic              cpu_halted;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        input  dbg_lock, cpu_halted,
        output dbg_locked,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        output dbg_lock, cpu_halted,
        input  dbg_locked,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between a CPU and a debug requester.
// Grants are combinational from the current requests and registered state.
// Round-robin on a tie; debug can take exclusive ownership through a
// three-state lock FSM (OPEN -> DRAIN -> LOCKED).
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : mem_port_arbiter_if.slave, all requester and memory signals
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    lock_state_t state_r;
    logic        dbg_locked_r;
    logic        last_owner_r;
    logic        rd_pending_r;
    logic        rd_owner_r;

    logic              cpu_elig_s;
    logic              dbg_elig_s;
    logic              cpu_gnt_s;
    logic              dbg_gnt_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              cpu_rd_issue_s;

    // Grant selection: CPU only competes while the lock FSM is OPEN and it is
    // not halted; on a tie the requester not granted last wins. Grants are
    // forced low while reset is asserted.
    always_comb begin
        cpu_elig_s = bus.cpu_req & ~bus.cpu_halted & (state_r == ST_OPEN);
        dbg_elig_s = bus.dbg_req;
        cpu_gnt_s  = 1'b0;
        dbg_gnt_s  = 1'b0;
        if (RST) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else if (cpu_elig_s && dbg_elig_s) begin
            if (last_owner_r == OWNER_CPU) begin
                dbg_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else if (cpu_elig_s) begin
            cpu_gnt_s = 1'b1;
        end else if (dbg_elig_s) begin
            dbg_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end
    end

    // Memory command mux: follows the granted requester, zero when idle.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            mem_we_s    = bus.cpu_we;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
        end else if (dbg_gnt_s) begin
            mem_we_s    = bus.dbg_we;
            mem_addr_s  = bus.dbg_addr;
            mem_wdata_s = bus.dbg_wdata;
        end else begin
            mem_we_s    = 1'b0;
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end
    end

    // A CPU read issued this cycle makes a cpu_rvalid due next cycle; DRAIN
    // waits on this before declaring debug the exclusive owner.
    assign cpu_rd_issue_s = cpu_gnt_s & ~bus.cpu_we;

    // Lock FSM with registered dbg_locked; releasing dbg_lock returns to OPEN
    // from either DRAIN or LOCKED on the next edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_OPEN;
            dbg_locked_r <= 1'b0;
        end else begin
            case (state_r)
                ST_OPEN: begin
                    dbg_locked_r <= 1'b0;
                    if (bus.dbg_lock) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_OPEN;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.dbg_lock) begin
                        state_r      <= ST_OPEN;
                        dbg_locked_r <= 1'b0;
                    end else if (!cpu_rd_issue_s) begin
                        state_r      <= ST_LOCKED;
                        dbg_locked_r <= 1'b1;
                    end else begin
                        state_r      <= ST_DRAIN;
                        dbg_locked_r <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (!bus.dbg_lock) begin
                        state_r      <= ST_OPEN;
                        dbg_locked_r <= 1'b0;
                    end else begin
                        state_r      <= ST_LOCKED;
                        dbg_locked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_OPEN;
                    dbg_locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin history and read-return tracking. rd_pending is rewritten
    // every cycle so back-to-back reads each produce one rvalid pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_owner_r <= OWNER_CPU;
            rd_pending_r <= 1'b0;
            rd_owner_r   <= OWNER_CPU;
        end else begin
            if (cpu_gnt_s) begin
                last_owner_r <= OWNER_CPU;
            end else if (dbg_gnt_s) begin
                last_owner_r <= OWNER_DBG;
            end else begin
                last_owner_r <= last_owner_r;
            end
            rd_pending_r <= (cpu_gnt_s | dbg_gnt_s) & ~mem_we_s;
            rd_owner_r   <= dbg_gnt_s ? OWNER_DBG : OWNER_CPU;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_s;
    assign bus.dbg_gnt    = dbg_gnt_s;
    assign bus.mem_en     = cpu_gnt_s | dbg_gnt_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.cpu_rvalid = rd_pending_r & (rd_owner_r == OWNER_CPU);
    assign bus.dbg_rvalid = rd_pending_r & (rd_owner_r == OWNER_DBG);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.dbg_locked = dbg_locked_r;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have ports `CLK` (input, 1) and `RST` (input, 1); one clock, rising edge; reset asynchronous, active-high.
REQ-004 SHALL have port `cpu_req` (input, 1): CPU requests an access.
REQ-005 SHALL have port `cpu_we` (input, 1): 1 = write, 0 = read.
REQ-006 SHALL have ports `cpu_addr` (input, ADDR_W) and `cpu_wdata` (input, DATA_W).
REQ-007 SHALL have ports `cpu_gnt` (output, 1): access issued this cycle; `cpu_rvalid` (output, 1): read data valid; `cpu_rdata` (output, DATA_W): read data.
REQ-008 SHALL have ports `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid` and `dbg_rdata`, with the same directions, widths and meanings as the CPU set, for the debug requester.
REQ-009 SHALL have port `dbg_lock` (input, 1): debug requests exclusive memory ownership.
REQ-010 SHALL have port `dbg_locked` (output, 1): exclusive ownership held by debug.
REQ-011 SHALL have port `cpu_halted` (input, 1): CPU held in reset; its requests are masked.
REQ-012 SHALL have ports `mem_en` (output, 1), `mem_we` (output, 1), `mem_addr` (output, ADDR_W) and `mem_wdata` (output, DATA_W): single-port memory command.
REQ-013 SHALL have port `mem_rdata` (input, DATA_W): valid the cycle after a read command.

Function
REQ-014 SHALL issue at most one memory command per cycle; mem_en = cpu_gnt | dbg_gnt; cpu_gnt and dbg_gnt never both 1.
REQ-015 SHALL generate grants combinationally from current requests and registered state; a requester holds req/we/addr/wdata stable until it sees gnt.
REQ-016 SHALL drive mem_we/mem_addr/mem_wdata from the granted requester, and drive 0 when there is no grant.
REQ-017 SHALL treat the CPU as eligible only when cpu_req=1, cpu_halted=0 and the lock FSM is in OPEN.
REQ-018 SHALL arbitrate round-robin when both requesters are eligible in OPEN: grant the requester not granted last; register last_owner on every grant; last_owner resets to CPU, so debug wins the first tie.
REQ-019 SHALL register rd_owner and rd_pending on a read grant; on the next cycle the owner's rvalid=1, for exactly one cycle; back-to-back reads SHALL be supported, one per cycle.
REQ-020 SHALL drive cpu_rdata and dbg_rdata = mem_rdata, meaningful only while the corresponding rvalid=1.
REQ-021 SHALL implement a lock FSM with states OPEN, DRAIN and LOCKED.
REQ-022 SHALL move OPEN->DRAIN when dbg_lock=1; in DRAIN and LOCKED the CPU is never granted, and debug requests are still granted.
REQ-023 SHALL move DRAIN->LOCKED once no CPU read is pending, i.e. no cpu_rvalid due the next cycle; if none is pending on entry, DRAIN SHALL last one cycle.
REQ-024 SHALL assert dbg_locked=1 only in LOCKED.
REQ-025 SHALL return from DRAIN or LOCKED to OPEN the cycle after dbg_lock=0.
REQ-026 SHALL on cpu_halted rising mid-operation drop no in-flight CPU read: its rvalid still fires.
REQ-027 SHALL, in the cycle a grant and an rvalid coincide, produce both independently.

Reset
REQ-028 SHALL on RST=1 asynchronously set the FSM=OPEN, last_owner=CPU, rd_pending=0; all gnt, rvalid, dbg_locked and mem_en outputs SHALL be 0.
REQ-029 SHALL during reset discard any read in flight: no rvalid after RST deasserts for pre-reset commands.

Verification
REQ-030 Single CPU read: cpu_req=1, we=0, addr=0x10 -> cpu_gnt and mem_en=1 in cycle 0; cpu_rvalid=1 with mem_rdata in cycle 1.
REQ-031 Contention: both req held for 4 cycles after reset -> grants DBG, CPU, DBG, CPU; never both in one cycle.
REQ-032 Lock with CPU read in flight: CPU read granted in cycle 0, dbg_lock=1 in cycle 0 -> cpu_rvalid in cycle 1, dbg_locked=1 in cycle 2, no cpu_gnt while dbg_lock=1.
REQ-033 Halted CPU: cpu_halted=1, cpu_req=1 for 10 cycles -> no cpu_gnt; dbg write addr=0x4, data=0xDEADBEEF granted immediately with mem_we=1.
REQ-034 Back-to-back debug reads at 0x0 then 0x4 -> dbg_rvalid in two consecutive cycles carrying the respective mem_rdata.
REQ-035 Reset mid-read: RST asserted the cycle after a read grant -> rvalid=0 and all outputs 0 immediately and after release.
